counter_display_top: RTL and testbench
======================================

# counter_display_top

Top-level free-running up counter with a programmable clock-enable prescaler and an 8-digit multiplexed seven-segment display driver. It sits at the board boundary. It takes the system clock, the switches and the buttons. It drives the segment, decimal-point and anode pins directly. The count is shown in hexadecimal or decimal, selected at run time.

## Interface
- SIZE, default 4: counter width in bits; legal range 1..26.
- REFRESH_BITS, default 2: sets the digit-scan period to 2^REFRESH_BITS clocks. Use 2 for simulation and 17 for hardware.
- top_port_clk  in  1  system clock; all state updates on its rising edge.
- top_port_rst  in  1  reset; synchronous, active-high.
- top_port_en  in  1  count enable; 0 freezes both the prescaler and the counter.
- top_port_sel  in  1  display radix: 0 = hexadecimal, 1 = decimal.
- top_port_idp  in  1  decimal-point request for digit 0; active-high.
- top_port_clk_factor  in  5  prescaler factor F; the count steps once every F+1 enabled clocks.
- top_port_ssd  out  7  segments {g,f,e,d,c,b,a}; active-low.
- top_port_odp  out  1  decimal-point segment; active-low.
- top_port_an  out  8  digit anodes; active-low, one-hot-low.

## Operation
- Prescaler:
  - 5-bit register P; acts on every clock where en=1.
  - If P >= F: P <= 0, and a tick occurs this cycle.
  - Otherwise: P <= P+1.
  - The >= comparison means a run-time decrease of F never stalls the prescaler.
- Counter:
  - SIZE-bit register C; C <= C+1 on each tick.
  - Wraps from 2^SIZE-1 to 0 with no flag.
- With en=0, P and C hold their values.
- Scan:
  - Free-running REFRESH_BITS-bit divider; not gated by en.
  - On divider wrap, digit index D (3 bits) increments 0..7 and wraps to 0.
- Digit value:
  - sel=0: nibble D of C, zero-extended.
  - sel=1: BCD digit D of C. Binary-to-BCD conversion is combinational (double-dabble).
- Leading-zero blanking:
  - A digit above the most significant non-zero digit has its anode driven high (off).
  - Digit 0 is always lit.
- Segment encoding: standard hex glyphs 0-9 and A-F; values above 9 never occur in decimal mode.
- Anode: top_port_an = ~(1<<D), unless the digit is blanked, in which case all ones.
- Decimal point: top_port_odp = ~top_port_idp when D=0, otherwise 1.
- Outputs are combinational decodes of the registered C, D and the inputs.

## Timing
- Synchronous reset clears P=0, C=0, D=0 and the scan divider to 0.
- Output values in reset, with idp=0:
  - ssd=7'b1000000 (glyph "0")
  - an=8'hFE
  - odp=1
- Reset takes priority over en in the same cycle.
- Reset asserted mid-count returns C to 0 at the next edge.
- Count latency for F=k with en held high after reset: C becomes 1 at the (k+1)th rising edge after reset release, then advances every k+1 clocks.
- F=0: C increments every clock.
- A change of sel affects the display in the same cycle (combinational) and never alters C.
- A change of F takes effect from the next prescaler comparison.
- Scan: each digit is active for exactly 2^REFRESH_BITS clocks; the full frame is 8·2^REFRESH_BITS clocks.

## Configuration
- Macro DECIMAL_DISPLAY_EN.
- Defined: the BCD converter is built, and sel=1 selects decimal display as described above.
- Undefined:
  - The BCD logic is omitted.
  - top_port_sel is ignored; the display is always hexadecimal.
  - All other behaviour is identical.

## Test plan
- Reset, then en=1, F=1, sel=0, SIZE=4, run 40 clocks:
  - C advances every 2 clocks: 1 at edge 2, 2 at edge 4, …, 15 at edge 30.
  - Wraps to 0 at edge 32.
  - Only digit 0 is ever lit, showing hex glyphs 0..F.
- Same run with sel=1 once C=12:
  - Digit 0 shows "2" (ssd=7'b0100100) and digit 1 shows "1" (ssd=7'b1111001).
  - an alternates 8'hFE / 8'hFD while D is 0 / 1.
  - Digits 2-7 stay blanked (an=8'hFF while D is 2..7).
- en=0 for 10 clocks at C=5: C stays 5 and P holds; resuming en continues from the held P.
- F=0: C increments on every edge. Change F from 7 to 2 while P=6: a tick on the next edge (P >= F), then one tick every 3 clocks.
- idp=1: odp=0 only while an=8'hFE, otherwise odp=1.
- Reset asserted with C=9: after the next edge C=0, an=8'hFE and ssd=7'b1000000.

Source files
------------

// File: rtl/counter_display_top.sv
// rtl/counter_display_top.sv - prescaled up counter with 8-digit multiplexed seven-segment driver (option macro: DECIMAL_DISPLAY_EN)

module counter_display_top #(
    parameter int SIZE         = 4,
    parameter int REFRESH_BITS = 2
) (
    input  logic       top_port_clk,
    input  logic       top_port_rst,
    input  logic       top_port_en,
    input  logic       top_port_sel,
    input  logic       top_port_idp,
    input  logic [4:0] top_port_clk_factor,
    output logic [6:0] top_port_ssd,
    output logic       top_port_odp,
    output logic [7:0] top_port_an
);

    logic [4:0]              p;
    logic [SIZE-1:0]         c;
    logic [REFRESH_BITS-1:0] div;
    logic [2:0]              d;
    logic                    tick;
    logic [31:0]             c_ext;
    logic [31:0]             digits;
    logic [2:0]              msd;
    logic [3:0]              digit_val;
    logic                    blank;

    // >= rather than == so lowering the factor mid-count never strands p above it
    assign tick = top_port_en && (p >= top_port_clk_factor);

    always_ff @(posedge top_port_clk) begin
        if (top_port_rst) begin
            p <= '0;
            c <= '0;
        end else if (top_port_en) begin
            if (tick) begin
                p <= '0;
                c <= c + SIZE'(1);
            end else begin
                p <= p + 5'd1;
            end
        end
    end

    always_ff @(posedge top_port_clk) begin
        if (top_port_rst) begin
            div <= '0;
            d   <= '0;
        end else begin
            div <= div + REFRESH_BITS'(1);
            if (&div) begin
                d <= d + 3'd1;
            end
        end
    end

    assign c_ext = 32'(c);

`ifdef DECIMAL_DISPLAY_EN
    logic [31:0] bcd;

    always_comb begin
        bcd = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            for (int j = 0; j < 8; j++) begin
                if (bcd[4*j +: 4] >= 4'd5) begin
                    bcd[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
                end
            end
            bcd = {bcd[30:0], c[i]};
        end
    end

    assign digits = top_port_sel ? bcd : c_ext;
`else
    logic unused_sel;
    assign unused_sel = top_port_sel;
    assign digits     = c_ext;
`endif

    always_comb begin
        msd = '0;
        for (int j = 1; j < 8; j++) begin
            if (digits[4*j +: 4] != 4'd0) begin
                msd = 3'(j);
            end
        end
    end

    assign blank     = (d > msd);
    assign digit_val = digits[{d, 2'b00} +: 4];

    always_comb begin
        case (digit_val)
            4'h0: top_port_ssd = 7'b1000000;
            4'h1: top_port_ssd = 7'b1111001;
            4'h2: top_port_ssd = 7'b0100100;
            4'h3: top_port_ssd = 7'b0110000;
            4'h4: top_port_ssd = 7'b0011001;
            4'h5: top_port_ssd = 7'b0010010;
            4'h6: top_port_ssd = 7'b0000010;
            4'h7: top_port_ssd = 7'b1111000;
            4'h8: top_port_ssd = 7'b0000000;
            4'h9: top_port_ssd = 7'b0010000;
            4'hA: top_port_ssd = 7'b0001000;
            4'hB: top_port_ssd = 7'b0000011;
            4'hC: top_port_ssd = 7'b1000110;
            4'hD: top_port_ssd = 7'b0100001;
            4'hE: top_port_ssd = 7'b0000110;
            default: top_port_ssd = 7'b0001110;
        endcase
    end

    assign top_port_an  = blank ? 8'hFF : ~(8'b1 << d);
    assign top_port_odp = (d == 3'd0) ? ~top_port_idp : 1'b1;

endmodule

// File: tb/tb_counter_display_top.sv
// tb/tb_counter_display_top.sv - directed vector bench for counter_display_top

module tb_counter_display_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       sel = 1'b0;
    logic       idp = 1'b0;
    logic [4:0] f   = 5'd0;
    logic [6:0] ssd;
    logic       odp;
    logic [7:0] an;

    int errors = 0;
    int checks = 0;

`ifdef DECIMAL_DISPLAY_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;

    logic [6:0] glyph [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        int         cyc;
        logic       rst;
        logic       en;
        logic       sel;
        logic       idp;
        logic [4:0] f;
        logic [3:0] c;
        logic [7:0] an;
        logic [6:0] ssd;
        logic       odp;
    } vec_t;

    vec_t vt[$];

    counter_display_top #(.SIZE(4), .REFRESH_BITS(2)) dut (
        .top_port_clk        (clk),
        .top_port_rst        (rst),
        .top_port_en         (en),
        .top_port_sel        (sel),
        .top_port_idp        (idp),
        .top_port_clk_factor (f),
        .top_port_ssd        (ssd),
        .top_port_odp        (odp),
        .top_port_an         (an)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int cyc, logic r, logic e, logic s, logic i, logic [4:0] ff,
                                logic [3:0] c, logic [7:0] a, logic [6:0] g, logic o);
        vec_t v;
        v.cyc = cyc; v.rst = r; v.en = e; v.sel = s; v.idp = i; v.f = ff;
        v.c = c; v.an = a; v.ssd = g; v.odp = o;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // n = edges since reset release; digit index = (n/4)%8, count = (n/2)%16 at F=1
        vt.push_back(mk( 1, 1, 0, 0, 0, 0,  0, 8'hFE, G0, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 1,  0, 8'hFE, G0, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 1,  1, 8'hFE, G1, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 1,  1, 8'hFE, G1, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 1,  2, 8'hFF, G0, 1));
        vt.push_back(mk(26, 0, 1, 0, 0, 1, 15, 8'hFF, G0, 1));
        vt.push_back(mk( 2, 0, 1, 0, 0, 1,  0, 8'hFE, G0, 1));
        vt.push_back(mk( 2, 0, 1, 0, 0, 1,  1, 8'hFE, G1, 1));
        vt.push_back(mk( 1, 0, 1, 0, 1, 1,  1, 8'hFE, G1, 0));
        vt.push_back(mk( 1, 0, 1, 0, 1, 1,  2, 8'hFF, G0, 1));
        vt.push_back(mk( 6, 0, 1, 0, 0, 1,  5, 8'hFF, G0, 1));
        vt.push_back(mk(10, 0, 0, 0, 0, 1,  5, 8'hFF, G0, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 1,  5, 8'hFF, G0, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 1,  6, 8'hFF, G0, 1));
        vt.push_back(mk( 1, 1, 0, 0, 0, 0,  0, 8'hFE, G0, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 0,  1, 8'hFE, G1, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 0,  2, 8'hFE, G2, 1));
        vt.push_back(mk( 6, 0, 1, 0, 0, 7,  2, 8'hFF, G0, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 2,  3, 8'hFF, G0, 1));
        vt.push_back(mk( 2, 0, 1, 0, 0, 2,  3, 8'hFF, G0, 1));
        vt.push_back(mk( 1, 0, 1, 0, 0, 2,  4, 8'hFF, G0, 1));
        vt.push_back(mk( 3, 0, 1, 0, 0, 2,  5, 8'hFF, G0, 1));
        vt.push_back(mk( 4, 0, 1, 0, 0, 0,  9, 8'hFF, G0, 1));
        vt.push_back(mk( 1, 1, 1, 0, 0, 0,  0, 8'hFE, G0, 1));

        #1;
        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; en = vt[i].en; sel = vt[i].sel; idp = vt[i].idp; f = vt[i].f;
            step(vt[i].cyc);
            chk($sformatf("vec%0d_count", i), 32'(dut.c), 32'(vt[i].c));
            chk($sformatf("vec%0d_an", i), 32'(an), 32'(vt[i].an));
            chk($sformatf("vec%0d_ssd", i), 32'(ssd), 32'(vt[i].ssd));
            chk($sformatf("vec%0d_odp", i), 32'(odp), 32'(vt[i].odp));
        end

        // glyph sweep: load count k at F=0, freeze, wait until the scan returns to digit 0
        for (int k = 0; k < 16; k++) begin
            rst = 1; en = 0; sel = 0; idp = 0; f = 0;
            step(1);
            rst = 0; en = 1;
            step(k);
            en = 0;
            step(32 - k);
            chk($sformatf("sweep%0d_count", k), 32'(dut.c), 32'(k));
            chk($sformatf("sweep%0d_ssd", k), 32'(ssd), 32'(glyph[k]));
            chk($sformatf("sweep%0d_an", k), 32'(an), 32'hFE);
        end

        // radix select at count 12
        rst = 1; en = 0; sel = 0; idp = 0; f = 0;
        step(1);
        rst = 0; en = 1;
        step(12);
        en = 0; sel = 1;
        step(20);
        chk("dec_d0_ssd", 32'(ssd), DEC ? 32'(G2) : 32'(7'b1000110));
        chk("dec_d0_an", 32'(an), 32'hFE);
        sel = 0;
        step(0);
        chk("hex_d0_ssd", 32'(ssd), 32'(7'b1000110));
        chk("sel_keeps_count", 32'(dut.c), 32'd12);
        sel = 1;
        step(4);
        chk("dec_d1_ssd", 32'(ssd), DEC ? 32'(G1) : 32'(G0));
        chk("dec_d1_an", 32'(an), DEC ? 32'hFD : 32'hFF);
        step(4);
        chk("dec_d2_an", 32'(an), 32'hFF);
        step(24);
        chk("dec_wrap_an", 32'(an), 32'hFE);
        chk("dec_final_count", 32'(dut.c), 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
